pll_lock_reset_seq: RTL and testbench
=====================================

PLL_LOCK_RESET_SEQ -- requirements
Module: pll_lock_reset_seq

Interface
REQ-001 The module SHALL have parameter DEBOUNCE, default 16, the number of consecutive synchronized-high lock cycles needed to treat lock as stable (range 1..255).
REQ-002 The module SHALL have parameter HOLD_CYCLES, default 1024, the number of cycles sys_rst is held after stable lock (range 1..65535).
REQ-003 The module SHALL have parameter TICK_DIV, default 120000, the tick period in clk cycles (1 ms at 120 MHz PLL output, range 2..2^20).
REQ-004 The module SHALL have port clk, input, width 1: the 120 MHz PLL output clock, the only clock.
REQ-005 The module SHALL have port rst, input, width 1: synchronous, active-high reset.
REQ-006 The module SHALL have port pll_lock, input, width 1: PLL lock indication, asynchronous to clk.
REQ-007 The module SHALL have port clr_lost, input, width 1: single-cycle clear of lock_lost.
REQ-008 The module SHALL have port sys_rst, output, width 1: registered active-high reset for downstream logic.
REQ-009 The module SHALL have port sys_ready, output, width 1: registered; the exact complement of sys_rst.
REQ-010 The module SHALL have port tick_1ms, output, width 1: one-cycle pulse every TICK_DIV cycles while in RUN.
REQ-011 The module SHALL have port lock_lost, output, width 1: sticky flag, set on loss of lock in RUN.
REQ-012 The module SHALL have port loss_count, output, width 8: saturating count of lock-loss events (present only with the macro).

Function
REQ-013 The module SHALL synchronize pll_lock through two flip-flops, giving 2 cycles of latency; all other logic SHALL use only the synchronized value.
REQ-014 The module SHALL assert lock_stable after DEBOUNCE consecutive synchronized-high cycles and SHALL deassert it on the first synchronized-low cycle.
REQ-015 The module SHALL implement the states WAIT_LOCK, HOLD and RUN.
REQ-016 In WAIT_LOCK the module SHALL assert sys_rst=1 and SHALL move to HOLD when lock_stable=1, clearing the hold counter.
REQ-017 In HOLD the module SHALL increment the hold counter, SHALL move to RUN when the counter equals HOLD_CYCLES-1, and SHALL return to WAIT_LOCK when lock_stable=0.
REQ-018 In RUN the module SHALL drive sys_rst=0, sys_ready=1, and SHALL move to WAIT_LOCK on lock_stable=0.
REQ-019 On the RUN to WAIT_LOCK transition the module SHALL set lock_lost and SHALL assert sys_rst on the next edge.
REQ-020 When pll_lock rises and stays high, sys_rst SHALL fall exactly 2+DEBOUNCE+HOLD_CYCLES+1 rising edges later.
REQ-021 The tick counter SHALL run only in RUN, counting 0..TICK_DIV-1 and pulsing tick_1ms on the cycle it wraps from TICK_DIV-1 to 0.
REQ-022 The tick counter SHALL be cleared to 0 on leaving RUN, and no tick SHALL occur outside RUN.
REQ-023 clr_lost SHALL clear lock_lost; when clr_lost coincides with a new loss event, the set SHALL win.
REQ-024 A glitch on pll_lock shorter than DEBOUNCE cycles during WAIT_LOCK or HOLD SHALL restart qualification and SHALL NOT set lock_lost.

Reset
REQ-025 With rst=1 the module SHALL enter WAIT_LOCK on the next edge, with sys_rst=1, sys_ready=0, tick_1ms=0, lock_lost=0, loss_count=0, and the synchronizer, debounce, hold and tick counters all at 0.
REQ-026 Reset asserted mid-RUN SHALL NOT set lock_lost or increment loss_count.

Configuration
REQ-027 The macro PLL_LOSS_COUNT_EN SHALL control the loss counter.
REQ-028 With PLL_LOSS_COUNT_EN defined, loss_count SHALL exist and increment on each RUN to WAIT_LOCK loss event, saturating at 255, and clr_lost SHALL also clear it.
REQ-029 Without PLL_LOSS_COUNT_EN, the port and its counter SHALL be absent, with all other behaviour unchanged.

Verification (DEBOUNCE=4, HOLD_CYCLES=8, TICK_DIV=10)
REQ-030 Scenario: rst released, pll_lock tied high -> sys_rst falls and sys_ready rises exactly 15 edges after pll_lock rises.
REQ-031 Scenario: in RUN for 35 cycles -> tick_1ms pulses at RUN cycles 10, 20 and 30, each 1 cycle wide.
REQ-032 Scenario: pll_lock pulsed high 3 cycles then low -> state stays WAIT_LOCK, sys_rst stays 1, lock_lost stays 0.
REQ-033 Scenario: in RUN, pll_lock drops -> sys_rst=1 within 4 edges, lock_lost=1, loss_count=1, tick_1ms stops; relock gives sys_rst low after another 15 edges.
REQ-034 Scenario: clr_lost asserted on the same cycle as a loss event -> lock_lost=1; clr_lost asserted alone later -> lock_lost=0, loss_count=0.
REQ-035 Scenario: 300 loss/relock cycles with the macro defined -> loss_count saturates at 255; rst mid-RUN -> sys_rst=1 and loss_count=0.

Source files
------------

// File: rtl/pll_lock_reset_seq.sv
// PLL lock qualification and downstream reset sequencer with a 1 ms tick while running.
// Optional saturating lock-loss counter enabled by defining PLL_LOSS_COUNT_EN.
module pll_lock_reset_seq #(
   parameter int DEBOUNCE    = 16,
   parameter int HOLD_CYCLES = 1024,
   parameter int TICK_DIV    = 120000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_lock,
   input  logic       clr_lost,
   output logic       sys_rst,
   output logic       sys_ready,
   output logic       tick_1ms,
   output logic       lock_lost,
`ifdef PLL_LOSS_COUNT_EN
   output logic [7:0] loss_count,
`endif
   // sequencer state: 0 = WAIT_LOCK, 1 = HOLD, 2 = RUN
   output logic [1:0] dbg_state
);

   localparam int              TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [7:0]      DEB_MAX   = 8'(DEBOUNCE);
   localparam logic [15:0]     HOLD_LAST = 16'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      HOLD      = 2'd1,
      RUN       = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            sync1_q, sync1_d;
   logic            sync2_q, sync2_d;
   logic [7:0]      deb_cnt_q, deb_cnt_d;
   logic            lock_stable_q, lock_stable_d;
   logic [15:0]     hold_cnt_q, hold_cnt_d;
   logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
   logic            sys_rst_q, sys_rst_d;
   logic            sys_ready_q, sys_ready_d;
   logic            lock_lost_q, lock_lost_d;
   logic            loss_event;
`ifdef PLL_LOSS_COUNT_EN
   logic [7:0]      loss_cnt_q, loss_cnt_d;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= WAIT_LOCK;
         sync1_q       <= 1'b0;
         sync2_q       <= 1'b0;
         deb_cnt_q     <= '0;
         lock_stable_q <= 1'b0;
         hold_cnt_q    <= '0;
         tick_cnt_q    <= '0;
         sys_rst_q     <= 1'b1;
         sys_ready_q   <= 1'b0;
         lock_lost_q   <= 1'b0;
`ifdef PLL_LOSS_COUNT_EN
         loss_cnt_q    <= '0;
`endif
      end else begin
         state_q       <= state_d;
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         deb_cnt_q     <= deb_cnt_d;
         lock_stable_q <= lock_stable_d;
         hold_cnt_q    <= hold_cnt_d;
         tick_cnt_q    <= tick_cnt_d;
         sys_rst_q     <= sys_rst_d;
         sys_ready_q   <= sys_ready_d;
         lock_lost_q   <= lock_lost_d;
`ifdef PLL_LOSS_COUNT_EN
         loss_cnt_q    <= loss_cnt_d;
`endif
      end
   end

   always_comb begin
      sync1_d = pll_lock;
      sync2_d = sync1_q;

      // Debounce count saturates at DEBOUNCE; stable exactly when saturated.
      deb_cnt_d = '0;
      if (sync2_q) begin
         deb_cnt_d = (deb_cnt_q == DEB_MAX) ? deb_cnt_q : deb_cnt_q + 8'd1;
      end
      lock_stable_d = (deb_cnt_d == DEB_MAX);

      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      loss_event = 1'b0;
      case (state_q)
         WAIT_LOCK: begin
            if (lock_stable_q) begin
               state_d    = HOLD;
               hold_cnt_d = '0;
            end
         end
         HOLD: begin
            if (!lock_stable_q) begin
               state_d = WAIT_LOCK;
            end else if (hold_cnt_q == HOLD_LAST) begin
               state_d = RUN;
            end else begin
               hold_cnt_d = hold_cnt_q + 16'd1;
            end
         end
         RUN: begin
            if (!lock_stable_q) begin
               state_d    = WAIT_LOCK;
               loss_event = 1'b1;
            end
         end
         default: state_d = WAIT_LOCK;
      endcase

      tick_cnt_d = '0;
      if ((state_q == RUN) && (state_d == RUN)) begin
         tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TW'(1);
      end

      sys_rst_d   = (state_d != RUN);
      sys_ready_d = (state_d == RUN);

      // A loss event beats a simultaneous clear.
      lock_lost_d = lock_lost_q;
      if (loss_event) begin
         lock_lost_d = 1'b1;
      end else if (clr_lost) begin
         lock_lost_d = 1'b0;
      end

`ifdef PLL_LOSS_COUNT_EN
      loss_cnt_d = loss_cnt_q;
      if (loss_event) begin
         loss_cnt_d = (loss_cnt_q == 8'hFF) ? loss_cnt_q : loss_cnt_q + 8'd1;
      end else if (clr_lost) begin
         loss_cnt_d = '0;
      end
`endif
   end

   assign sys_rst   = sys_rst_q;
   assign sys_ready = sys_ready_q;
   assign tick_1ms  = (state_q == RUN) && (tick_cnt_q == TICK_LAST);
   assign lock_lost = lock_lost_q;
   assign dbg_state = state_q;
`ifdef PLL_LOSS_COUNT_EN
   assign loss_count = loss_cnt_q;
`endif

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Bench for pll_lock_reset_seq: run-length reference model feeding a per-cycle scoreboard,
// plus directed latency/tick/loss checks. Define PLL_LOSS_COUNT_EN to also check loss_count.
module tb_pll_lock_reset_seq;

   localparam int D = 4;
   localparam int H = 8;
   localparam int T = 10;
   localparam int W = 14;
`ifdef PLL_LOSS_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst      = 1'b1;
   logic       pll_lock = 1'b0;
   logic       clr_lost = 1'b0;
   logic       sys_rst, sys_ready, tick_1ms, lock_lost;
   logic [1:0] dbg_state;
   logic [7:0] cnt_obs;

`ifdef PLL_LOSS_COUNT_EN
   logic [7:0] loss_count;
   assign cnt_obs = loss_count;
`else
   assign cnt_obs = 8'd0;
`endif

   pll_lock_reset_seq #(
      .DEBOUNCE   (D),
      .HOLD_CYCLES(H),
      .TICK_DIV   (T)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .pll_lock  (pll_lock),
      .clr_lost  (clr_lost),
      .sys_rst   (sys_rst),
      .sys_ready (sys_ready),
      .tick_1ms  (tick_1ms),
      .lock_lost (lock_lost),
`ifdef PLL_LOSS_COUNT_EN
      .loss_count(loss_count),
`endif
      .dbg_state (dbg_state)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [W-1:0] exp_q[$];

   // reference model: run lengths of raw lock, of stable lock, and of RUN
   int lr0 = 0, lr1 = 0, lr2 = 0;
   int srun = 0, run_len = 0, m_cnt = 0;
   bit prev_in_run = 1'b0, m_lost = 1'b0;

   task automatic model_edge(input bit l, input bit c, input bit r, output logic [W-1:0] e);
      bit in_run, hold, stable, loss, tk;
      logic [1:0] st;
      if (r) begin
         lr0 = 0; lr1 = 0; lr2 = 0;
         srun = 0; run_len = 0; m_cnt = 0;
         prev_in_run = 1'b0; m_lost = 1'b0;
         e = {2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
      end else begin
         lr2 = lr1;
         lr1 = lr0;
         lr0 = l ? lr0 + 1 : 0;
         stable = (lr2 >= D);
         in_run = (srun >= H + 1);
         hold   = !in_run && (srun >= 1);
         srun   = stable ? srun + 1 : 0;
         loss   = prev_in_run && !in_run;
         if (loss) begin
            m_lost = 1'b1;
            if (m_cnt < 255) m_cnt++;
         end else if (c) begin
            m_lost = 1'b0;
            m_cnt  = 0;
         end
         run_len     = in_run ? run_len + 1 : 0;
         prev_in_run = in_run;
         tk = in_run && (run_len % T == 0);
         st = in_run ? 2'd2 : (hold ? 2'd1 : 2'd0);
         e  = {st, !in_run, in_run, tk, m_lost, CNT_EN ? 8'(m_cnt) : 8'd0};
      end
   endtask

   // driver: one clock edge per call; outputs of that edge are settled on return
   task automatic step(input bit l, input bit c, input bit r);
      logic [W-1:0] e;
      @(negedge clk);
      pll_lock = l;
      clr_lost = c;
      rst      = r;
      model_edge(l, c, r, e);
      exp_q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // scoreboard monitor
   logic [W-1:0] mon_exp, mon_act;
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         mon_act = {dbg_state, sys_rst, sys_ready, tick_1ms, lock_lost, cnt_obs};
         n_checks++;
         if (mon_act !== mon_exp) begin
            n_fail++;
            if (n_fail <= 20)
               $display("FAIL scoreboard t=%0t: got %h expected %h", $time, mon_act, mon_exp);
         end
      end
   end

   int lat, rc, nt;
   int tick_at[$];
   bit val;

   initial begin
      repeat (3) step(0, 0, 1);
      check("reset_sys_rst", sys_rst, 1);
      check("reset_sys_ready", sys_ready, 0);
      check("reset_tick", tick_1ms, 0);
      check("reset_lock_lost", lock_lost, 0);
      check("reset_state", dbg_state, 0);
`ifdef PLL_LOSS_COUNT_EN
      check("reset_loss_count", loss_count, 0);
`endif
      repeat (2) step(0, 0, 0);

      // short glitch in WAIT_LOCK
      repeat (3) step(1, 0, 0);
      repeat (12) step(0, 0, 0);
      check("glitch_wait_state", dbg_state, 0);
      check("glitch_wait_sys_rst", sys_rst, 1);
      check("glitch_wait_lost", lock_lost, 0);

      // lock drops during HOLD
      repeat (8) step(1, 0, 0);
      check("hold_entered", dbg_state, 1);
      repeat (8) step(0, 0, 0);
      check("glitch_hold_state", dbg_state, 0);
      check("glitch_hold_lost", lock_lost, 0);

      // lock rise latency and ticks over 35 RUN cycles
      lat = 0; rc = 0;
      for (int n = 1; n <= 60; n++) begin
         step(1, 0, 0);
         if (lat == 0 && sys_ready === 1'b1) lat = n;
         if (lat != 0) begin
            rc++;
            if (tick_1ms === 1'b1) tick_at.push_back(rc);
         end
         if (rc == 35) break;
      end
      check("rise_latency", lat, 15);
      check("tick_count", tick_at.size(), 3);
      for (int i = 0; i < 3; i++)
         check($sformatf("tick_pos%0d", i), (i < tick_at.size()) ? tick_at[i] : -1, 10 * (i + 1));

      // loss of lock in RUN
      lat = 0;
      for (int n = 1; n <= 10; n++) begin
         step(0, 0, 0);
         if (lat == 0 && sys_rst === 1'b1) lat = n;
      end
      check("loss_latency", lat, 4);
      check("loss_lost", lock_lost, 1);
`ifdef PLL_LOSS_COUNT_EN
      check("loss_count_one", loss_count, 1);
`endif
      nt = 0;
      for (int n = 0; n < 25; n++) begin
         step(0, 0, 0);
         if (tick_1ms === 1'b1) nt++;
      end
      check("ticks_after_loss", nt, 0);

      step(0, 1, 0);
      check("clr_alone_lost", lock_lost, 0);
`ifdef PLL_LOSS_COUNT_EN
      check("clr_alone_count", loss_count, 0);
`endif
      step(0, 0, 0);

      // relock
      lat = 0;
      for (int n = 1; n <= 30; n++) begin
         step(1, 0, 0);
         if (lat == 0 && sys_ready === 1'b1) begin
            lat = n;
            break;
         end
      end
      check("relock_latency", lat, 15);

      // clear coincident with loss event: set wins
      repeat (3) step(0, 0, 0);
      step(0, 1, 0);
      check("coincident_lost", lock_lost, 1);
`ifdef PLL_LOSS_COUNT_EN
      check("coincident_count", loss_count, 1);
`endif
      repeat (2) step(0, 0, 0);
      step(0, 1, 0);
      check("clr_later_lost", lock_lost, 0);
`ifdef PLL_LOSS_COUNT_EN
      check("clr_later_count", loss_count, 0);
`endif

      // randomized lock segments with sporadic clears and resets
      val = 1'b1;
      for (int s = 0; s < 80; s++) begin
         int len;
         len = $urandom_range(1, 30);
         for (int n = 0; n < len; n++)
            step(val, $urandom_range(0, 15) == 0, $urandom_range(0, 299) == 0);
         val = !val;
      end

      // repeated loss/relock to saturate the loss counter
      step(0, 1, 0);
      for (int i = 0; i < 300; i++) begin
         repeat (16) step(1, 0, 0);
         repeat (4) step(0, 0, 0);
      end
      check("sat_lost", lock_lost, 1);
`ifdef PLL_LOSS_COUNT_EN
      check("sat_count", loss_count, 255);
`endif

      // reset asserted mid-RUN
      repeat (20) step(1, 0, 0);
      check("pre_rst_run", sys_ready, 1);
      step(1, 0, 1);
      check("mid_rst_sys_rst", sys_rst, 1);
      check("mid_rst_lost", lock_lost, 0);
`ifdef PLL_LOSS_COUNT_EN
      check("mid_rst_count", loss_count, 0);
`endif
      repeat (20) step(1, 0, 0);
      check("post_rst_run", sys_ready, 1);
      check("post_rst_lost", lock_lost, 0);

      step(0, 0, 0);
      check("queue_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
